bus_snapshot_fifo: RTL and testbench
====================================

# bus_snapshot_fifo

Capture buffer sitting directly downstream of the registered bus stage (the E/F/G/H register bank). On each cycle where the capture strobe is high, it snapshots the four registered buses into a small FIFO. It presents the snapshots to a consumer over a valid/ready handshake. The VPI co-simulation harness uses it to compare bus traffic without sampling on every clock edge.

## Interface
- `ADDR_W`, default 2: log2 of FIFO depth; legal 1..4; DEPTH = 2**ADDR_W.
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `CAP`  in  1  capture strobe; sample E/F/G/H this edge.
- `E`  in  1  upstream single-bit register output.
- `F`  in  4  upstream 4-bit register output.
- `G`  in  8  upstream 8-bit register output.
- `H`  in  32  upstream 32-bit register output.
- `OUT_VALID`  out  1  FIFO non-empty; head entry on OUT_DATA.
- `OUT_READY`  in  1  consumer accepts head entry.
- `OUT_DATA`  out  45  head entry, packed {E,F,G,H]: bit 44 = E, 43:40 = F, 39:32 = G, 31:0 = H.
- `COUNT`  out  ADDR_W+1  number of stored entries, 0..DEPTH.
- `OVERFLOW`  out  1  sticky; a capture was dropped.
- `DROP_CNT`  out  8  saturating count of dropped captures.
- `CLR_OVF`  in  1  synchronous clear of OVERFLOW and DROP_CNT.
- `OUT_PAR`  out  1  even parity of head entry; present only with BUS_SNAPSHOT_PARITY_EN.

## Operation
- Storage: DEPTH-entry register array; write pointer, read pointer and COUNT; pointers wrap modulo DEPTH.
- Push condition: CAP && (COUNT < DEPTH || pop).
  - Writes {E,F,G,H} at the write pointer, then advances it.
- Pop condition: OUT_VALID && OUT_READY; advances the read pointer.
- COUNT update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Full and CAP with simultaneous pop: push is accepted; COUNT stays DEPTH.
- Empty: OUT_VALID = 0 and OUT_READY is ignored. CAP on an empty FIFO is a plain push; there is no bypass.
- Drop condition: CAP && COUNT == DEPTH && !pop. The entry is discarded.
  - OVERFLOW is set.
  - DROP_CNT increments, saturating at 255.
- CLR_OVF: zeroes OVERFLOW and DROP_CNT.
  - If a drop happens in the same cycle, the drop is applied after the clear: OVERFLOW = 1, DROP_CNT = 1.
- OUT_DATA = mem[read pointer]. It is stable while OUT_VALID && !OUT_READY.
- FIFO state machine: EMPTY (COUNT=0), PARTIAL, FULL (COUNT=DEPTH). Transitions are driven only by the push/pop rules above.

## Timing
- Reset (RST_N low, asynchronous):
  - OUT_VALID = 0, COUNT = 0, OVERFLOW = 0, DROP_CNT = 0, both pointers = 0.
  - OUT_DATA = 0 and OUT_PAR = 0 (array contents are cleared).
- Reset asserted mid-operation discards all entries immediately. Deassertion takes effect at the next rising edge.
- Latency: a capture at edge N gives OUT_VALID = 1 and OUT_DATA = that snapshot after edge N, i.e. visible in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- COUNT, OVERFLOW and DROP_CNT are registered and update at the same edge as the push/pop/drop that causes them.
- The upstream stage registers E/F/G/H on the same CLK. CAP at edge N samples the values that stage updated at edge N-1.

## Configuration
- `BUS_SNAPSHOT_PARITY_EN` defined:
  - Each entry is 46 bits.
  - Even parity over the 45 data bits is computed at push and stored alongside the data.
  - OUT_PAR is a port giving the stored parity of the head entry. OUT_PAR XOR ^OUT_DATA == 0.
- Undefined: OUT_PAR port absent; 45-bit entries; no parity logic.

## Test plan
- Reset, then CAP for one cycle with E=1, F=4'hA, G=8'h5C, H=32'hDEADBEEF, OUT_READY=0 -> next cycle OUT_VALID=1, OUT_DATA=45'h1A_5C_DEADBEEF, COUNT=1.
- With DEPTH=4 and OUT_READY=0, apply 6 consecutive CAPs (H=1..6) -> COUNT=4, OVERFLOW=1, DROP_CNT=2. Then draining yields H=1,2,3,4 in order.
- With the FIFO full and OUT_READY=1, apply CAP with H=7 -> head pops, H=7 is accepted, COUNT stays 4, DROP_CNT unchanged.
- 300 drops -> DROP_CNT saturates at 255. CLR_OVF together with another drop -> OVERFLOW=1, DROP_CNT=1.
- Assert RST_N=0 mid-drain with COUNT=3 -> OUT_VALID and COUNT go to 0 without waiting for a clock edge. After release, the first CAP appears as head.
- With BUS_SNAPSHOT_PARITY_EN, capture H=32'h1 with all other buses 0 -> OUT_PAR=1. Capture H=32'h3 with all other buses 0 -> OUT_PAR=0.

Source files
------------

// File: rtl/bus_snapshot_fifo.sv
// bus_snapshot_fifo
// Capture FIFO for the registered E/F/G/H bus stage. When the capture strobe is
// high on a rising edge, the four buses are stored as one packed entry
// {e, f, g, h}. A consumer reads the entries through a valid/ready handshake.
// If a capture arrives while the FIFO is full and nothing pops in that cycle,
// the capture is dropped. A drop sets a sticky overflow flag and increments a
// saturating drop counter.
//
// Optional feature macro: BUS_SNAPSHOT_PARITY_EN. When it is defined, each
// entry also stores even parity over its 45 data bits, and the stored parity of
// the head entry is driven on out_par.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset; clears all state and the array
//   cap        capture strobe
//   e/f/g/h    upstream buses, widths 1/4/8/32
//   out_valid  FIFO is non-empty; the head entry is on out_data
//   out_ready  consumer accepts the head entry
//   out_data   head entry {e, f, g, h}
//   count      number of stored entries, 0..2**ADDR_W
//   overflow   sticky flag: at least one capture was dropped
//   drop_cnt   number of dropped captures, saturating at 255
//   clr_ovf    synchronous clear of overflow and drop_cnt
//   out_par    stored even parity of the head entry (parity build only)
module bus_snapshot_fifo #(
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap,
    input  logic              e,
    input  logic [3:0]        f,
    input  logic [7:0]        g,
    input  logic [31:0]       h,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [44:0]       out_data,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        drop_cnt,
`ifdef BUS_SNAPSHOT_PARITY_EN
    input  logic              clr_ovf,
    output logic              out_par
`else
    input  logic              clr_ovf
`endif
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(Depth);
`ifdef BUS_SNAPSHOT_PARITY_EN
    localparam int unsigned EntW = 46;
`else
    localparam int unsigned EntW = 45;
`endif

    typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

    state_e              state_q, state_d;
    logic [EntW-1:0]     mem_q [Depth];
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic                full, push, pop, drop;
    logic [44:0]         wr_data;
    logic [EntW-1:0]     wr_entry;

    assign wr_data = {e, f, g, h};
`ifdef BUS_SNAPSHOT_PARITY_EN
    assign wr_entry = {^wr_data, wr_data};
`else
    assign wr_entry = wr_data;
`endif

    assign out_valid = (state_q != StEmpty);
    assign full      = (state_q == StFull);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees a slot, so a capture on a full FIFO still lands.
    assign push      = cap && (!full || pop);
    assign drop      = cap && full && !pop;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        state_d = StPartial;
        if (count_d == '0) begin
            state_d = StEmpty;
        end else if (count_d == DepthCnt) begin
            state_d = StFull;
        end

        // The clear is applied first, so a drop in the same cycle is kept.
        overflow_d = clr_ovf ? 1'b0 : overflow_q;
        drop_cnt_d = clr_ovf ? 8'd0 : drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != 8'hFF) begin
                drop_cnt_d = drop_cnt_d + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= wr_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign out_data = mem_q[rd_ptr_q][44:0];
    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
`ifdef BUS_SNAPSHOT_PARITY_EN
    assign out_par  = mem_q[rd_ptr_q][45];
`endif

endmodule

// File: tb/tb_bus_snapshot_fifo.sv
module tb_bus_snapshot_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cap = 1'b0, e = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
    logic [3:0]  f = '0;
    logic [7:0]  g = '0;
    logic [31:0] h = '0;
    logic        out_valid, overflow;
    logic [44:0] out_data;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;
`ifdef BUS_SNAPSHOT_PARITY_EN
    logic        out_par;
`endif

    int tests = 0;
    int fails = 0;

    bus_snapshot_fifo #(.ADDR_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap       (cap),
        .e         (e),
        .f         (f),
        .g         (g),
        .h         (h),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
`ifdef BUS_SNAPSHOT_PARITY_EN
        .clr_ovf   (clr_ovf),
        .out_par   (out_par)
`else
        .clr_ovf   (clr_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cap;
        logic        e;
        logic [3:0]  f;
        logic [7:0]  g;
        logic [31:0] h;
        logic        rdy;
        logic        clr;
        logic        x_valid;
        logic [44:0] x_data;
        logic [2:0]  x_count;
        logic        x_ovf;
        logic [7:0]  x_drop;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic c, logic ee, logic [3:0] ff, logic [7:0] gg,
                                logic [31:0] hh, logic r, logic cl, logic xv,
                                logic [44:0] xd, logic [2:0] xc, logic xo,
                                logic [7:0] xdr);
        vec_t v;
        v.cap = c; v.e = ee; v.f = ff; v.g = gg; v.h = hh; v.rdy = r; v.clr = cl;
        v.x_valid = xv; v.x_data = xd; v.x_count = xc; v.x_ovf = xo; v.x_drop = xdr;
        return v;
    endfunction

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic drive(input logic c, input logic ee, input logic [3:0] ff,
                         input logic [7:0] gg, input logic [31:0] hh,
                         input logic r, input logic cl);
        @(negedge clk);
        cap = c; e = ee; f = ff; g = gg; h = hh; out_ready = r; clr_ovf = cl;
        @(posedge clk);
        #1;
    endtask

    // Data is compared only when the expected valid is 1.
    task automatic check(input string name, input logic xv, input logic [44:0] xd,
                         input logic [2:0] xc, input logic xo, input logic [7:0] xdr);
        tests++;
        if (out_valid !== xv || count !== xc || overflow !== xo || drop_cnt !== xdr ||
            (xv && out_data !== xd)) begin
            fails++;
            $display("FAIL %s: got valid=%b data=%h count=%0d ovf=%b drop=%0d, want valid=%b data=%h count=%0d ovf=%b drop=%0d",
                     name, out_valid, out_data, count, overflow, drop_cnt,
                     xv, xd, xc, xo, xdr);
        end
    endtask

    initial begin
        // The fields are cap, e, f, g, h, rdy, clr, then the expected valid, data, count, ovf, drop.
        vecs[0]  = mk(1, 1, 4'hA, 8'h5C, 32'hDEADBEEF, 0, 0, 1, 45'h1A_5C_DEADBEEF, 1, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 45'h0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 1, 0, 0, 1, 45'h1, 1, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 2, 0, 0, 1, 45'h1, 2, 0, 0);
        vecs[4]  = mk(1, 0, 0, 0, 3, 0, 0, 1, 45'h1, 3, 0, 0);
        vecs[5]  = mk(1, 0, 0, 0, 4, 0, 0, 1, 45'h1, 4, 0, 0);
        vecs[6]  = mk(1, 0, 0, 0, 5, 0, 0, 1, 45'h1, 4, 1, 1);
        vecs[7]  = mk(1, 0, 0, 0, 6, 0, 0, 1, 45'h1, 4, 1, 2);
        // A capture on a full FIFO with a pop in the same cycle is accepted.
        vecs[8]  = mk(1, 0, 0, 0, 7, 1, 0, 1, 45'h2, 4, 1, 2);
        vecs[9]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 45'h3, 3, 1, 2);
        vecs[10] = mk(0, 0, 0, 0, 0, 1, 0, 1, 45'h4, 2, 1, 2);
        vecs[11] = mk(0, 0, 0, 0, 0, 1, 0, 1, 45'h7, 1, 1, 2);
        vecs[12] = mk(0, 0, 0, 0, 0, 1, 0, 0, 45'h0, 0, 1, 2);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 0, 45'h0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 0, 45'h0, 0, 0, 0);
        tests++;
        if (out_data !== 45'h0) begin
            fails++;
            $display("FAIL reset_data: got %h want 0", out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].cap, vecs[i].e, vecs[i].f, vecs[i].g, vecs[i].h,
                  vecs[i].rdy, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].x_valid, vecs[i].x_data,
                  vecs[i].x_count, vecs[i].x_ovf, vecs[i].x_drop);
        end

        // Saturation: fill the FIFO, then drop 300 captures.
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 32'h10 + i, 0, 0);
        check("fill4", 1, 45'h10, 4, 0, 0);
        for (int i = 0; i < 300; i++) drive(1, 0, 0, 0, 32'hFF, 0, 0);
        check("drop_saturate", 1, 45'h10, 4, 1, 255);
        drive(1, 0, 0, 0, 32'hFF, 0, 1);
        check("clr_with_drop", 1, 45'h10, 4, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("clr_only", 1, 45'h10, 4, 0, 0);

        // Asynchronous reset in the middle of a drain.
        drive(0, 0, 0, 0, 0, 1, 0);
        check("pre_reset_pop", 1, 45'h11, 3, 0, 0);
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset", 0, 45'h0, 0, 0, 0);
        tests++;
        if (out_data !== 45'h0) begin
            fails++;
            $display("FAIL async_reset_data: got %h want 0", out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 32'h55, 0, 0);
        check("post_reset_cap", 1, 45'h55, 1, 0, 0);

        // Parity, with the bus values from the parity checks.
        drive(0, 0, 0, 0, 0, 1, 0);
        check("empty_again", 0, 45'h0, 0, 0, 0);
        drive(1, 0, 0, 0, 32'h1, 0, 0);
        check("cap_h1", 1, 45'h1, 1, 0, 0);
`ifdef BUS_SNAPSHOT_PARITY_EN
        tests++;
        if (out_par !== 1'b1) begin
            fails++;
            $display("FAIL par_h1: got %b want 1", out_par);
        end
`endif
        drive(1, 0, 0, 0, 32'h3, 1, 0);
        check("cap_h3_pop", 1, 45'h3, 1, 0, 0);
`ifdef BUS_SNAPSHOT_PARITY_EN
        tests++;
        if (out_par !== 1'b0) begin
            fails++;
            $display("FAIL par_h3: got %b want 0", out_par);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
